// File: rtl/proc_pkg.sv
// proc_pkg: shared register-file widths, the zero-register index and the write-back entry type
package proc_pkg;
   localparam int REG_AW = 5;
   localparam int REG_DW = 32;
   localparam int REG_ZERO = 0;
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [REG_DW-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous count-based FIFO of (rd, data) writes exposing every slot and its valid bit
module wb_fifo import proc_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int AW = REG_AW,
   parameter int DW = REG_DW,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [AW-1:0] i_rd,
   input  logic [DW-1:0] i_data,
   input  logic          i_pop,
   output logic [PW:0]   o_cnt,
   output logic [PW-1:0] o_rptr,
   output logic [AW-1:0] o_head_rd,
   output logic [DW-1:0] o_head_data,
   output logic [AW-1:0] o_rd [DEPTH],
   output logic [DW-1:0] o_data [DEPTH],
   output logic          o_vld [DEPTH]
);
   logic [PW-1:0] r_wptr, r_rptr;
   logic [PW:0]   r_cnt;
   logic [AW-1:0] r_rd [DEPTH];
   logic [DW-1:0] r_data [DEPTH];
   // pointers wrap modulo DEPTH; the count resolves full versus empty
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (i_push) begin
            r_rd[r_wptr]   <= i_rd;
            r_data[r_wptr] <= i_data;
            r_wptr         <= r_wptr + 1'b1;
         end
         if (i_pop) r_rptr <= r_rptr + 1'b1;
         r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(i_pop);
      end
   end
   // a slot is valid when its distance from the read pointer is below the count
   always_comb begin
      for (int i = 0; i < DEPTH; i++) o_vld[i] = {1'b0, PW'(i) - r_rptr} < r_cnt;
   end
   assign o_cnt       = r_cnt;
   assign o_rptr      = r_rptr;
   assign o_head_rd   = r_rd[r_rptr];
   assign o_head_data = r_data[r_rptr];
   assign o_rd        = r_rd;
   assign o_data      = r_data;
endmodule

// File: rtl/regfile_wb_port.sv
// regfile_wb_port: buffers write-back results and drains one register-file write per cycle; REGFILE_WB_FWD_EN adds operand forwarding
module regfile_wb_port import proc_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int AW = REG_AW,
   parameter int DW = REG_DW,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_valid,
   input  logic [AW-1:0] wb_rd,
   input  logic [DW-1:0] wb_data,
   output logic          wb_ready,
   input  logic          drain_hold,
   output logic          rf_we,
   output logic [AW-1:0] rf_rd,
   output logic [DW-1:0] rf_data,
   input  logic [AW-1:0] rd_rs,
   input  logic [AW-1:0] rd_rt,
   output logic          hazard_rs,
   output logic          hazard_rt,
`ifdef REGFILE_WB_FWD_EN
   output logic          fwd_a_valid,
   output logic [DW-1:0] fwd_a_data,
   output logic          fwd_b_valid,
   output logic [DW-1:0] fwd_b_data,
`endif
   output logic [PW:0]   pend_cnt
);
   logic          w_push, w_pop, w_haz_rs, w_haz_rt;
   logic [PW-1:0] w_rptr;
   logic [AW-1:0] w_head_rd;
   logic [DW-1:0] w_head_data;
   logic [AW-1:0] w_rd [DEPTH];
   logic [DW-1:0] w_data [DEPTH];
   logic          w_vld [DEPTH];
   logic          r_we;
   logic [AW-1:0] r_rd;
   logic [DW-1:0] r_data;
   assign wb_ready = rst && (pend_cnt != (PW+1)'(DEPTH));
   assign w_push   = wb_valid && wb_ready && (wb_rd != AW'(REG_ZERO));
   assign w_pop    = (pend_cnt != '0) && !drain_hold;
   wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
      .clk(clk), .rst(rst), .i_push(w_push), .i_rd(wb_rd), .i_data(wb_data), .i_pop(w_pop),
      .o_cnt(pend_cnt), .o_rptr(w_rptr), .o_head_rd(w_head_rd), .o_head_data(w_head_data),
      .o_rd(w_rd), .o_data(w_data), .o_vld(w_vld)
   );
   // output stage: strobe one write per pop, hold index and data otherwise
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_we   <= 1'b0;
         r_rd   <= '0;
         r_data <= '0;
      end else begin
         r_we <= w_pop;
         if (w_pop) begin
            r_rd   <= w_head_rd;
            r_data <= w_head_data;
         end
      end
   end
   assign rf_we   = r_we;
   assign rf_rd   = r_rd;
   assign rf_data = r_data;
   // scan output stage then FIFO oldest to youngest; later matches overwrite so the youngest value wins
   always_comb begin
      logic [PW-1:0] idx;
      w_haz_rs = r_we && (r_rd == rd_rs);
      w_haz_rt = r_we && (r_rd == rd_rt);
`ifdef REGFILE_WB_FWD_EN
      fwd_a_data = r_data;
      fwd_b_data = r_data;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         idx = w_rptr + PW'(k);
         if (w_vld[idx] && (w_rd[idx] == rd_rs)) begin
            w_haz_rs = 1'b1;
`ifdef REGFILE_WB_FWD_EN
            fwd_a_data = w_data[idx];
`endif
         end
         if (w_vld[idx] && (w_rd[idx] == rd_rt)) begin
            w_haz_rt = 1'b1;
`ifdef REGFILE_WB_FWD_EN
            fwd_b_data = w_data[idx];
`endif
         end
      end
      hazard_rs = w_haz_rs && (rd_rs != AW'(REG_ZERO));
      hazard_rt = w_haz_rt && (rd_rt != AW'(REG_ZERO));
`ifdef REGFILE_WB_FWD_EN
      fwd_a_valid = hazard_rs;
      fwd_b_valid = hazard_rt;
`endif
   end
endmodule
